// File: rtl/apb_ucpd_tx_sched_if.sv
// Control bundle between the UCPD register bank / PD FSM and the transmit scheduler.
// The slave modport is the scheduler's view; master is the view of whoever drives it.
interface apb_ucpd_tx_sched_if #(
    parameter int TW_W = 8,
    parameter int IG_W = 8
);
    logic            ucpden;
    logic            bit_tick;
    logic            txsend_req;
    logic            txhrst_req;
    logic [1:0]      tx_mode;
    logic [TW_W-1:0] transwin_val;
    logic [IG_W-1:0] ifrgap_val;
    logic            rx_busy;
    logic            tx_active;
    logic            tx_und;

    logic            transmit_en;
    logic            tx_hrst;
    logic            tx_hrst_flag;
    logic            tx_crst_flag;
    logic            transwin_en;
    logic            ifrgap_en;
    logic            sched_busy;
    logic            txmsgsent;
    logic            txmsgdisc;
    logic            txmsgabt;
    logic            hrstsent;
    logic            hrstdisc;

    modport slave (
        input  ucpden, bit_tick, txsend_req, txhrst_req, tx_mode, transwin_val,
               ifrgap_val, rx_busy, tx_active, tx_und,
        output transmit_en, tx_hrst, tx_hrst_flag, tx_crst_flag, transwin_en,
               ifrgap_en, sched_busy, txmsgsent, txmsgdisc, txmsgabt, hrstsent, hrstdisc
    );

    modport master (
        output ucpden, bit_tick, txsend_req, txhrst_req, tx_mode, transwin_val,
               ifrgap_val, rx_busy, tx_active, tx_und,
        input  transmit_en, tx_hrst, tx_hrst_flag, tx_crst_flag, transwin_en,
               ifrgap_en, sched_busy, txmsgsent, txmsgdisc, txmsgabt, hrstsent, hrstdisc
    );
endinterface

// File: rtl/apb_ucpd_tx_sched.sv
// UCPD transmit scheduler: latches TXSEND/TXHRST, waits out the line-idle window,
// drives the TX FSM request controls and times the interframe gap in half-bit ticks.
module apb_ucpd_tx_sched #(
    parameter int TW_W = 8,
    parameter int IG_W = 8
) (
    input  logic               ic_clk,
    input  logic               ic_rst,
    apb_ucpd_tx_sched_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WIN,
        S_ARM,
        S_BUSY,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic            pend_msg_q, pend_msg_d;
    logic            pend_hrst_q, pend_hrst_d;
    logic            und_seen_q, und_seen_d;
    logic            job_hrst_q, job_hrst_d;
    logic            crst_q, crst_d;
    logic            preempt_q, preempt_d;
    logic            tx_active_q;
    logic [TW_W-1:0] tw_cnt_q, tw_cnt_d;
    logic [IG_W-1:0] ig_cnt_q, ig_cnt_d;

    logic msg_live, tx_fall, req_phase;
    logic msgsent_d, msgdisc_d, msgabt_d, hrstsent_d, hrstdisc_d, ifrgap_d;

    function automatic logic [TW_W-1:0] tw_inc(input logic [TW_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [IG_W-1:0] ig_inc(input logic [IG_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        pend_msg_d  = pend_msg_q;
        pend_hrst_d = pend_hrst_q;
        und_seen_d  = und_seen_q;
        job_hrst_d  = job_hrst_q;
        crst_d      = crst_q;
        preempt_d   = preempt_q;
        tw_cnt_d    = tw_cnt_q;
        ig_cnt_d    = ig_cnt_q;
        msgsent_d   = 1'b0;
        msgdisc_d   = 1'b0;
        msgabt_d    = 1'b0;
        hrstsent_d  = 1'b0;
        hrstdisc_d  = 1'b0;
        ifrgap_d    = 1'b0;
        msg_live    = (state_q == S_WIN || state_q == S_ARM || state_q == S_BUSY) && !job_hrst_q;
        tx_fall     = tx_active_q && !bus.tx_active;

        case (state_q)
            S_IDLE: begin
                // hard reset always takes precedence over a pending message
                if (pend_hrst_q || pend_msg_q) begin
                    if (bus.rx_busy) begin
                        if (pend_hrst_q) begin
                            hrstdisc_d  = 1'b1;
                            pend_hrst_d = 1'b0;
                        end else begin
                            msgdisc_d  = 1'b1;
                            pend_msg_d = 1'b0;
                        end
                    end else begin
                        job_hrst_d = pend_hrst_q;
                        tw_cnt_d   = '0;
                        state_d    = S_WIN;
                    end
                end
            end
            S_WIN: begin
                if (bus.rx_busy) begin
                    if (job_hrst_q) begin
                        hrstdisc_d  = 1'b1;
                        pend_hrst_d = 1'b0;
                    end else begin
                        msgdisc_d  = 1'b1;
                        pend_msg_d = 1'b0;
                    end
                    state_d = S_IDLE;
                end else if (tw_cnt_q == bus.transwin_val) begin
                    crst_d    = !job_hrst_q && (bus.tx_mode == 2'd1);
                    preempt_d = 1'b0;
                    if (job_hrst_q) pend_hrst_d = 1'b0;
                    else            pend_msg_d  = 1'b0;
                    state_d = S_ARM;
                end else if (bus.bit_tick) begin
                    tw_cnt_d = tw_inc(tw_cnt_q);
                end
            end
            S_ARM: begin
                if (bus.tx_active) state_d = S_BUSY;
            end
            S_BUSY: begin
                if (!job_hrst_q && bus.tx_und)     und_seen_d = 1'b1;
                if (!job_hrst_q && bus.txhrst_req) preempt_d  = 1'b1;
                // same-cycle underrun or pre-emption still marks the message aborted
                if (tx_fall) begin
                    if (job_hrst_q)                    hrstsent_d = 1'b1;
                    else if (und_seen_d || preempt_d)  msgabt_d   = 1'b1;
                    else                               msgsent_d  = 1'b1;
                    und_seen_d = 1'b0;
                    preempt_d  = 1'b0;
                    crst_d     = 1'b0;
                    ig_cnt_d   = '0;
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                if (ig_cnt_q == bus.ifrgap_val) begin
                    ifrgap_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (bus.bit_tick) begin
                    ig_cnt_d = ig_inc(ig_cnt_q);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // a new request arriving on the same cycle as a clear survives it
        if (bus.txhrst_req) pend_hrst_d = 1'b1;
        if (bus.txsend_req) begin
            if (pend_msg_q || msg_live) msgdisc_d  = 1'b1;
            else                        pend_msg_d = 1'b1;
        end

        req_phase = (state_d == S_ARM) || (state_d == S_BUSY);
    end

    always_ff @(posedge ic_clk) begin
        if (ic_rst || !bus.ucpden) begin
            state_q          <= S_IDLE;
            pend_msg_q       <= 1'b0;
            pend_hrst_q      <= 1'b0;
            und_seen_q       <= 1'b0;
            job_hrst_q       <= 1'b0;
            crst_q           <= 1'b0;
            preempt_q        <= 1'b0;
            tx_active_q      <= 1'b0;
            tw_cnt_q         <= '0;
            ig_cnt_q         <= '0;
            bus.transmit_en  <= 1'b0;
            bus.tx_hrst      <= 1'b0;
            bus.tx_hrst_flag <= 1'b0;
            bus.tx_crst_flag <= 1'b0;
            bus.transwin_en  <= 1'b0;
            bus.ifrgap_en    <= 1'b0;
            bus.sched_busy   <= 1'b0;
            bus.txmsgsent    <= 1'b0;
            bus.txmsgdisc    <= 1'b0;
            bus.txmsgabt     <= 1'b0;
            bus.hrstsent     <= 1'b0;
            bus.hrstdisc     <= 1'b0;
        end else begin
            state_q          <= state_d;
            pend_msg_q       <= pend_msg_d;
            pend_hrst_q      <= pend_hrst_d;
            und_seen_q       <= und_seen_d;
            job_hrst_q       <= job_hrst_d;
            crst_q           <= crst_d;
            preempt_q        <= preempt_d;
            tx_active_q      <= bus.tx_active;
            tw_cnt_q         <= tw_cnt_d;
            ig_cnt_q         <= ig_cnt_d;
            bus.transmit_en  <= req_phase && !job_hrst_d;
            bus.tx_hrst      <= req_phase && (job_hrst_d || preempt_d);
            bus.tx_hrst_flag <= req_phase && job_hrst_d;
            bus.tx_crst_flag <= req_phase && crst_d;
            bus.transwin_en  <= (state_d == S_ARM);
            bus.ifrgap_en    <= ifrgap_d;
            bus.sched_busy   <= (state_d != S_IDLE);
            bus.txmsgsent    <= msgsent_d;
            bus.txmsgdisc    <= msgdisc_d;
            bus.txmsgabt     <= msgabt_d;
            bus.hrstsent     <= hrstsent_d;
            bus.hrstdisc     <= hrstdisc_d;
        end
    end

endmodule

// File: tb/tb_apb_ucpd_tx_sched.sv
// Bench for apb_ucpd_tx_sched: scripted opening scenarios, then random traffic,
// every cycle compared against a job-level reference model of the scheduler.
module tb_apb_ucpd_tx_sched;
    localparam int TW_W  = 8;
    localparam int IG_W  = 8;
    localparam int N_CYC = 8000;
    localparam int N_DIR = 400;

    localparam int PH_IDLE = 0, PH_WIN = 1, PH_ARM = 2, PH_BUSY = 3, PH_GAP = 4;
    localparam int J_NONE = 0, J_MSG = 1, J_HRST = 2;

    logic ic_clk = 1'b0;
    logic ic_rst = 1'b1;
    always #5 ic_clk = ~ic_clk;

    apb_ucpd_tx_sched_if #(.TW_W(TW_W), .IG_W(IG_W)) bus ();

    apb_ucpd_tx_sched #(.TW_W(TW_W), .IG_W(IG_W)) dut (
        .ic_clk (ic_clk),
        .ic_rst (ic_rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got=%03h expected=%03h", tag, $time, got, exp);
        end
    endtask

    // reference model state
    int         m_phase   = PH_IDLE;
    int         m_job     = J_NONE;
    int         m_elapsed = 0;
    bit         m_pm = 0, m_ph = 0, m_und = 0, m_pre = 0, m_crst = 0, m_act = 0;
    logic [11:0] m_exp = '0;

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic drop_job(output bit h_disc, output bit m_disc, input int job);
        h_disc = 0;
        m_disc = 0;
        if (job == J_HRST) begin h_disc = 1; m_ph = 0; end
        else               begin m_disc = 1; m_pm = 0; end
    endtask

    task automatic model_step();
        bit st_sent = 0, st_disc = 0, st_abt = 0, h_sent = 0, h_disc = 0, gap_pulse = 0;
        bit fall, latch_msg = 0, msg_job_live, in_req, hd, md;
        if (ic_rst || !bus.ucpden) begin
            m_phase = PH_IDLE; m_job = J_NONE; m_elapsed = 0;
            m_pm = 0; m_ph = 0; m_und = 0; m_pre = 0; m_crst = 0; m_act = 0;
            m_exp = '0;
            return;
        end
        fall = m_act && !bus.tx_active;
        msg_job_live = (m_job == J_MSG) &&
                       (m_phase == PH_WIN || m_phase == PH_ARM || m_phase == PH_BUSY);
        if (bus.txsend_req) begin
            if (m_pm || msg_job_live) st_disc = 1;
            else                      latch_msg = 1;
        end
        case (m_phase)
            PH_IDLE: if (m_ph || m_pm) begin
                if (bus.rx_busy) begin
                    drop_job(hd, md, m_ph ? J_HRST : J_MSG);
                    h_disc |= hd; st_disc |= md;
                end else begin
                    m_job = m_ph ? J_HRST : J_MSG;
                    m_elapsed = 0;
                    m_phase = PH_WIN;
                end
            end
            PH_WIN: begin
                if (bus.rx_busy) begin
                    drop_job(hd, md, m_job);
                    h_disc |= hd; st_disc |= md;
                    m_job = J_NONE;
                    m_phase = PH_IDLE;
                end else if (sat8(m_elapsed) == int'(bus.transwin_val)) begin
                    m_crst = (m_job == J_MSG) && (bus.tx_mode == 2'd1);
                    if (m_job == J_HRST) m_ph = 0; else m_pm = 0;
                    m_phase = PH_ARM;
                end else if (bus.bit_tick) begin
                    m_elapsed++;
                end
            end
            PH_ARM: if (bus.tx_active) m_phase = PH_BUSY;
            PH_BUSY: begin
                if (m_job == J_MSG && bus.tx_und)     m_und = 1;
                if (m_job == J_MSG && bus.txhrst_req) m_pre = 1;
                if (fall) begin
                    if (m_job == J_HRST)     h_sent = 1;
                    else if (m_und || m_pre) st_abt = 1;
                    else                     st_sent = 1;
                    m_und = 0; m_pre = 0; m_crst = 0; m_job = J_NONE;
                    m_elapsed = 0;
                    m_phase = PH_GAP;
                end
            end
            PH_GAP: begin
                if (sat8(m_elapsed) == int'(bus.ifrgap_val)) begin
                    gap_pulse = 1;
                    m_phase = PH_IDLE;
                end else if (bus.bit_tick) begin
                    m_elapsed++;
                end
            end
            default: ;
        endcase
        if (bus.txhrst_req) m_ph = 1;
        if (latch_msg)      m_pm = 1;
        m_act  = bus.tx_active;
        in_req = (m_phase == PH_ARM) || (m_phase == PH_BUSY);
        m_exp = {in_req && (m_job == J_MSG),
                 in_req && (m_job == J_HRST || m_pre),
                 in_req && (m_job == J_HRST),
                 in_req && m_crst,
                 m_phase == PH_ARM,
                 gap_pulse,
                 m_phase != PH_IDLE,
                 st_sent, st_disc, st_abt, h_sent, h_disc};
    endtask

    function automatic logic [11:0] dut_outs();
        return {bus.transmit_en, bus.tx_hrst, bus.tx_hrst_flag, bus.tx_crst_flag,
                bus.transwin_en, bus.ifrgap_en, bus.sched_busy, bus.txmsgsent,
                bus.txmsgdisc, bus.txmsgabt, bus.hrstsent, bus.hrstdisc};
    endfunction

    // bench-side TX FSM: answers a request with a burst of tx_active
    bit phy_act = 0, phy_done = 0;
    int phy_wait = 0, phy_len = 0;
    int en_low = 0;

    task automatic drive(input int cyc);
        bit req;
        req = bus.transmit_en || bus.tx_hrst;
        bus.txsend_req = 1'b0;
        bus.txhrst_req = 1'b0;
        bus.tx_und     = 1'b0;
        ic_rst         = (cyc < 4);

        if (phy_act) begin
            if (phy_len == 0) begin phy_act = 0; phy_done = 1; end
            else phy_len--;
        end else if (req) begin
            if (!phy_done) begin
                if (phy_wait == 0) begin
                    phy_act = 1;
                    phy_len = (cyc < N_DIR) ? 19 : int'($urandom_range(0, 7));
                end else phy_wait--;
            end
        end else begin
            phy_done = 0;
            phy_wait = int'($urandom_range(0, 3));
        end
        bus.tx_active = phy_act;

        if (cyc < N_DIR) begin
            bus.ucpden       = 1'b1;
            bus.bit_tick     = cyc[0];
            bus.transwin_val = 8'd3;
            bus.ifrgap_val   = 8'd2;
            bus.rx_busy      = (cyc >= 190 && cyc <= 205) || (cyc >= 224 && cyc <= 226);
            bus.tx_mode      = (cyc >= 240) ? 2'd1 : 2'd0;
            if (cyc == 10 || cyc == 90 || cyc == 195 || cyc == 220 || cyc == 240 ||
                cyc == 255 || cyc == 300) bus.txsend_req = 1'b1;
            if (cyc == 90 || cyc == 262) bus.txhrst_req = 1'b1;
            if (cyc >= 325 && cyc <= 327) bus.tx_und = 1'b1;
        end else begin
            bus.bit_tick = ($urandom_range(0, 2) != 0);
            if (bus.rx_busy) begin
                if ($urandom_range(0, 4) == 0) bus.rx_busy = 1'b0;
            end else if ($urandom_range(0, 24) == 0) bus.rx_busy = 1'b1;
            if ($urandom_range(0, 9) == 0)  bus.txsend_req = 1'b1;
            if ($urandom_range(0, 39) == 0) bus.txhrst_req = 1'b1;
            if ($urandom_range(0, 49) == 0) begin
                bus.txsend_req = 1'b1;
                bus.txhrst_req = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) bus.tx_und = 1'b1;
            if ($urandom_range(0, 19) == 0) bus.tx_mode = 2'($urandom_range(0, 3));
            if (m_phase == PH_IDLE && $urandom_range(0, 15) == 0) begin
                bus.transwin_val = ($urandom_range(0, 24) == 0) ? 8'hFF : 8'($urandom_range(0, 5));
                bus.ifrgap_val   = 8'($urandom_range(0, 5));
            end
            if (en_low > 0) begin
                en_low--;
                bus.ucpden = 1'b0;
            end else begin
                bus.ucpden = 1'b1;
                if (m_phase == PH_BUSY && $urandom_range(0, 59) == 0) begin
                    bus.ucpden = 1'b0;
                    en_low = 1;
                end
            end
            if (m_phase == PH_GAP && $urandom_range(0, 39) == 0) ic_rst = 1'b1;
        end
    endtask

    initial begin
        bus.ucpden       = 1'b1;
        bus.bit_tick     = 1'b0;
        bus.txsend_req   = 1'b0;
        bus.txhrst_req   = 1'b0;
        bus.tx_mode      = 2'd0;
        bus.transwin_val = 8'd3;
        bus.ifrgap_val   = 8'd2;
        bus.rx_busy      = 1'b0;
        bus.tx_active    = 1'b0;
        bus.tx_und       = 1'b0;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge ic_clk);
            #1;
            drive(cyc);
            @(negedge ic_clk);
            chk((cyc < 5) ? "reset_outs" : "outs", dut_outs(), m_exp);
            model_step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_ucpd_tx_sched.md
# apb_ucpd_tx_sched

Transmit scheduler for the UCPD PHY. It sits between the APB register bank and the PD TX/RX main FSM. It latches software TXSEND/TXHRST commands and arbitrates hard reset ahead of a normal message. It enforces line-idle (transmit window) and interframe-gap timing in half-bit ticks, drives the FSM's `transmit_en`/`tx_hrst`/`transwin_en`/`ifrgap_en` controls, and reports one-cycle status events (sent, discarded, aborted).

## Interface
Parameters:
- `TW_W`, 8, width of transmit-window count and counter
- `IG_W`, 8, width of interframe-gap count and counter

Ports:
- `ic_clk` in 1: single block clock (HSI16 domain); all logic on rising edge
- `ic_rst` in 1: reset, synchronous, active-high
- `ucpden` in 1: peripheral enable; low = synchronous soft clear
- `bit_tick` in 1: one-cycle half-bit strobe
- `txsend_req` in 1: one-cycle pulse, SW TXSEND
- `txhrst_req` in 1: one-cycle pulse, SW TXHRST
- `tx_mode` in 2: 0 normal SOP, 1 cable reset, 2 BIST; 3 treated as 0; sampled at ARM entry
- `transwin_val` in TW_W: line-idle ticks required before start
- `ifrgap_val` in IG_W: gap ticks after end of transmission
- `rx_busy` in 1: RX FSM not idle
- `tx_active` in 1: TX FSM driving line (bmc_en)
- `tx_und` in 1: TX underrun, level or pulse
- `transmit_en` out 1: message request to TX FSM
- `tx_hrst` out 1: hard-reset request to TX FSM
- `tx_hrst_flag` out 1: current job is hard reset
- `tx_crst_flag` out 1: current job is cable reset
- `transwin_en` out 1: transmit window open
- `ifrgap_en` out 1: one-cycle pulse, gap elapsed
- `sched_busy` out 1: state != IDLE
- `txmsgsent`, `txmsgdisc`, `txmsgabt`, `hrstsent`, `hrstdisc` out 1 each: one-cycle status pulses

## Operation
- All outputs are registered. All outputs reset to 0 under `ic_rst` or `ucpden`=0.
- The soft clear also sets the state to IDLE and clears pend_msg, pend_hrst, und_seen and both counters. No status pulse is generated.
- Request latch:
  - `txhrst_req` sets pend_hrst.
  - `txsend_req` sets pend_msg unless pend_msg is set or a message job is active. In that case it pulses `txmsgdisc` and the request is dropped.
- States: IDLE, WIN, ARM, BUSY, GAP.
- IDLE:
  - Stays in IDLE if no request is pending.
  - If pend_hrst is set, the job is hard reset. Otherwise, if pend_msg is set, the job is message. Hard reset always wins.
  - If `rx_busy`=1: pulse `hrstdisc` or `txmsgdisc`, clear that pend bit, stay in IDLE.
  - Else: clear the tick counter, go to WIN.
- WIN:
  - Counts `bit_tick` while `rx_busy`=0.
  - If `rx_busy` rises: discard the job (same pulse and clear as in IDLE), go to IDLE.
  - When count == `transwin_val`, go to ARM. A value of 0 gives ARM on the cycle after WIN entry.
- ARM:
  - `transwin_en`=1.
  - Assert `transmit_en` (message) or `tx_hrst` plus `tx_hrst_flag` (hard reset).
  - `tx_crst_flag` = (`tx_mode`==1) for a message job.
  - Clear the pend bit. Go to BUSY on the first cycle `tx_active`=1.
- BUSY:
  - Hold the request outputs. `transwin_en`=0.
  - `tx_und`=1 with a message job sets und_seen.
  - `txhrst_req` during a message job sets pend_hrst and asserts `tx_hrst` for the rest of BUSY; the message ends as aborted.
- End of transmission: `tx_active` falling edge, sampled against a registered copy.
  - Next cycle, pulse exactly one of:
    - `hrstsent` for a hard-reset job;
    - `txmsgabt` for a message with und_seen or a pre-empting hard reset;
    - `txmsgsent` otherwise.
  - Drop all request and flag outputs, clear und_seen and the counter, go to GAP.
- GAP:
  - Counts `bit_tick`.
  - When count == `ifrgap_val`, pulse `ifrgap_en` for one cycle and go to IDLE. A value of 0 pulses on the cycle after GAP entry.
  - Pending requests are serviced only from IDLE.
- Counters saturate at all-ones and never wrap.

## Timing
- Request pulse at cycle N: the pend bit is visible at N+1. With `rx_busy`=0 and `transwin_val`=0, state is WIN at N+2 and ARM at N+3, with `transmit_en` high at N+3.
- Discard pulses occur one cycle after the decision.
- Simultaneous `txsend_req` and `txhrst_req`: both latch; the hard reset is scheduled first and the message after GAP.
- `rx_busy` and the `transwin_val`-th tick on the same WIN cycle: `rx_busy` wins and the job is discarded.
- `tx_active` falling edge and `txhrst_req` on the same cycle: the message is reported `txmsgabt` and the hard reset stays pending.

## Test plan
- Message send, `rx_busy`=0, transwin_val=3, ifrgap_val=2, tx_active 20 cycles → `transmit_en` rises after 3 ticks; `txmsgsent` 1 cycle after tx_active falls; `ifrgap_en` after 2 more ticks; back to IDLE.
- `txsend_req` with `rx_busy`=1 → `txmsgdisc` pulse at N+2, `transmit_en` never asserted; `rx_busy` rising mid-WIN → `txmsgdisc`, IDLE.
- Simultaneous send and hrst with tx_mode=0 → `tx_hrst`/`hrstsent` first, then `transmit_en`/`txmsgsent`; exactly one pulse each.
- `tx_und`=1 in BUSY → `txmsgabt` only; `txhrst_req` in BUSY → `tx_hrst`=1, `txmsgabt`, then a hard-reset job after GAP giving `hrstsent`.
- tx_mode=1 → `tx_crst_flag`=1 during ARM/BUSY. Second `txsend_req` while BUSY → `txmsgdisc` and no queued message.
- `ucpden`=0 mid-BUSY, and `ic_rst` mid-GAP → all outputs 0 next cycle, pend bits cleared, no status pulses.
